bayer_quad_binarizer: RTL and testbench
=======================================

# bayer_quad_binarizer

Parametrised successor to the IPU raw-to-binary stage. Accepts raw Bayer pixels from the capture path. Averages each 2x2 quad to one grey sample using an internal line buffer, then classifies it against a programmable background window with optional polarity inversion. It also accumulates a per-frame foreground pixel count for the downstream tracking logic.

## Interface
Parameters:
- DATA_W, 12, raw pixel and grey sample width
- LINE_W, 1280, pixels per line; depth of the internal line buffer
- CNT_W, 22, width of the foreground counter

Ports:
- iCLK  in  1  single clock; all logic is rising-edge
- iRST_N  in  1  asynchronous, active-low reset
- iDATA  in  DATA_W  raw Bayer pixel
- iDVAL  in  1  pixel valid; also the line-buffer shift enable
- iX_Cont  in  16  column of the current pixel
- iY_Cont  in  16  row of the current pixel
- iFrame_En  in  1  high for the duration of a frame
- iTH_LO  in  DATA_W  background window lower bound, inclusive
- iTH_HI  in  DATA_W  background window upper bound, inclusive
- iINVERT  in  1  1 = swap the foreground and background codes
- oGrey  out  DATA_W  quad-average grey sample
- oBinary  out  1  1 = foreground, 0 = background (before inversion)
- oDVAL  out  1  oGrey and oBinary are valid
- oFG_COUNT  out  CNT_W  foreground count for the last completed frame
- oCOUNT_VAL  out  1  one-cycle pulse when oFG_COUNT updates

## Operation
- **Line buffer:** LINE_W x DATA_W shift register, advanced only when iDVAL=1. Its tap supplies the same-column pixel from the previous line. Columns at or beyond LINE_W are unsupported.
- **Previous-column registers:** one-deep registers hold the previous current-line pixel and the previous tap. They load only on iDVAL=1.
- **Quad sum:** a + b + a_d + b_d, computed at DATA_W+2 bits with no overflow. grey = sum[DATA_W+1:2], which truncates.
- **Quad-complete condition:** iDVAL=1 and iFrame_En=1 and iX_Cont[0]=1 and iY_Cont[0]=1. Only a quad-complete pixel produces an output. No other pixel asserts oDVAL.
- **Shadow thresholds:** iTH_LO, iTH_HI and iINVERT are captured into shadow registers on the first cycle iFrame_En is high after being low. Changes mid-frame take effect only at the next frame.
- **Classification:**
  - A sample is background when TH_LO <= grey <= TH_HI; raw binary = 0, otherwise 1.
  - oBinary = raw binary XOR INVERT.
  - If TH_LO > TH_HI the window is empty and raw binary is 1 for every sample.
- **Foreground counter:** increments on each cycle with oDVAL=1 and oBinary=1. It saturates at 2^CNT_W-1 and does not wrap.
- **Frame end:** begins on the first cycle iFrame_En is low after being high.
  - 3 cycles later, counter + any same-cycle increment is latched into oFG_COUNT.
  - oCOUNT_VAL pulses for 1 cycle and the counter clears in that same cycle.
- **Frame gap:** iFrame_En must stay low for at least 4 cycles. A shorter gap is unsupported; the latched count is then undefined.

## Timing
- **Reset values (iRST_N=0):**
  - oGrey, oBinary, oDVAL, oFG_COUNT, oCOUNT_VAL = 0.
  - Counter, pipeline and previous-column registers = 0.
  - Shadow registers = 0: window [0,0], INVERT=0.
  - Line-buffer contents are not reset; the first line after reset yields don't-care grey values.
- Reset mid-frame aborts the frame: no oCOUNT_VAL for that frame.
- **Pipeline, 2 stages:**
  - Cycle N: quad-complete input sampled.
  - Cycle N+1: sum and valid registered.
  - Cycle N+2: oGrey, oBinary and oDVAL registered and visible.
- oDVAL is a single-cycle pulse per quad.
- Back-to-back quad-complete inputs are impossible because X alternates, so at most one output every 2 valid cycles.
- iDVAL gaps stall the line buffer and previous-column registers but do not stall in-flight pipeline stages.
- The frame-end latch 3 cycles after the iFrame_En fall covers the 2-stage pipeline plus the counter update. Quads sampled in the last valid cycle of the frame are counted.
- When a saturation increment coincides with the latch cycle, the latched value is 2^CNT_W-1.

## Test plan
- **Flat field:** all pixels 1000, window [205,255], INVERT=0, 8x4 frame -> from line 1, every quad gives oGrey=1000 and oBinary=1. oDVAL arrives 2 cycles after each odd-X/odd-Y input. oFG_COUNT=8 with oCOUNT_VAL 3 cycles after the iFrame_En fall.
- **Quad arithmetic:** quad pixels 4095, 4095, 4095, 4094 -> oGrey=4094 (sum 16379 >> 2). Quad 210, 211, 212, 213 with window [205,255] -> oGrey=211, oBinary=0.
- **Inversion and empty window:**
  - INVERT=1, window [205,255], grey 211 -> oBinary=1.
  - TH_LO=300, TH_HI=100 -> every sample oBinary=1 with INVERT=0.
- **Shadow capture:** change iTH_HI from 255 to 100 mid-frame -> classification unchanged until the next iFrame_En rise, then grey 211 becomes foreground.
- **Saturation and iDVAL gaps:**
  - CNT_W=3, 10 foreground quads -> oFG_COUNT=7.
  - Random iDVAL deassertion -> identical oGrey sequence to a gap-free run.
- **Reset mid-frame:** assert iRST_N=0 during line 3 -> all outputs 0 within the same cycle. No oCOUNT_VAL until a full subsequent frame completes, and that frame's count excludes pre-reset pixels.

Source files
------------

// File: rtl/bayer_quad_binarizer.sv
// Bayer 2x2 quad averager with windowed binarisation and per-frame foreground count.
// One grey/binary sample per completed quad, two register stages after the input.
module bayer_quad_binarizer #(
   parameter int DATA_W = 12,
   parameter int LINE_W = 1280,
   parameter int CNT_W  = 22
) (
   input  logic              iCLK,
   input  logic              iRST_N,
   input  logic [DATA_W-1:0] iDATA,
   input  logic              iDVAL,
   input  logic [15:0]       iX_Cont,
   input  logic [15:0]       iY_Cont,
   input  logic              iFrame_En,
   input  logic [DATA_W-1:0] iTH_LO,
   input  logic [DATA_W-1:0] iTH_HI,
   input  logic              iINVERT,
   output logic [DATA_W-1:0] oGrey,
   output logic              oBinary,
   output logic              oDVAL,
   output logic [CNT_W-1:0]  oFG_COUNT,
   output logic              oCOUNT_VAL
);

   localparam int SUM_W = DATA_W + 2;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // Line buffer (no reset: contents of the first line are don't-care)
   logic [DATA_W-1:0] lb_q [LINE_W];
   logic [DATA_W-1:0] lb_d [LINE_W];
   logic [DATA_W-1:0] tap;

   // Previous-column registers
   logic [DATA_W-1:0] a_d_q, a_d_d;
   logic [DATA_W-1:0] b_d_q, b_d_d;

   // Stage 1
   logic              quad_done;
   logic [SUM_W-1:0]  sum_q, sum_d;
   logic              vld1_q, vld1_d;

   // Stage 2 (outputs)
   logic [DATA_W-1:0] grey_q, grey_d;
   logic              bin_q, bin_d;
   logic              dval_q, dval_d;
   logic              raw_bin;

   // Frame tracking and shadow thresholds
   logic              fe_q, fe_d;
   logic              frame_rise, frame_fall;
   logic [DATA_W-1:0] sh_lo_q, sh_lo_d;
   logic [DATA_W-1:0] sh_hi_q, sh_hi_d;
   logic              sh_inv_q, sh_inv_d;
   logic              fall1_q, fall1_d;
   logic              fall2_q, fall2_d;

   // Foreground counter
   logic              fg_inc;
   logic              latch_now;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  cnt_inc;
   logic [CNT_W-1:0]  fg_count_q, fg_count_d;
   logic              count_val_q, count_val_d;

   // Only the parity of the position counters matters here
   logic              unused_pos;
   assign unused_pos = ^{iX_Cont[15:1], iY_Cont[15:1]};

   assign tap = lb_q[LINE_W-1];

   always_comb begin
      lb_d = lb_q;
      if (iDVAL) begin
         lb_d[0] = iDATA;
         for (int i = 1; i < LINE_W; i++) begin
            lb_d[i] = lb_q[i-1];
         end
      end
   end

   always_ff @(posedge iCLK) begin
      lb_q <= lb_d;
   end

   always_comb begin
      a_d_d = a_d_q;
      b_d_d = b_d_q;
      if (iDVAL) begin
         a_d_d = iDATA;
         b_d_d = tap;
      end

      quad_done = iDVAL & iFrame_En & iX_Cont[0] & iY_Cont[0];
      vld1_d    = quad_done;
      sum_d     = sum_q;
      if (quad_done) begin
         sum_d = {2'b00, iDATA} + {2'b00, tap} + {2'b00, a_d_q} + {2'b00, b_d_q};
      end
   end

   // An empty window (lo > hi) can never contain grey, so raw_bin is 1 there
   always_comb begin
      grey_d  = grey_q;
      bin_d   = bin_q;
      dval_d  = vld1_q;
      raw_bin = 1'b0;
      if (vld1_q) begin
         grey_d  = sum_q[SUM_W-1:2];
         raw_bin = !((grey_d >= sh_lo_q) && (grey_d <= sh_hi_q));
         bin_d   = raw_bin ^ sh_inv_q;
      end
   end

   always_comb begin
      fe_d       = iFrame_En;
      frame_rise = iFrame_En & ~fe_q;
      frame_fall = ~iFrame_En & fe_q;

      sh_lo_d  = sh_lo_q;
      sh_hi_d  = sh_hi_q;
      sh_inv_d = sh_inv_q;
      if (frame_rise) begin
         sh_lo_d  = iTH_LO;
         sh_hi_d  = iTH_HI;
         sh_inv_d = iINVERT;
      end

      fall1_d = frame_fall;
      fall2_d = fall1_q;
   end

   // The latch waits out the two pipeline stages plus the counter update
   always_comb begin
      latch_now = fall2_q;
      fg_inc    = dval_q & bin_q;
      cnt_inc   = cnt_q;
      if (fg_inc && (cnt_q != CNT_MAX)) begin
         cnt_inc = cnt_q + CNT_W'(1);
      end

      cnt_d       = cnt_inc;
      fg_count_d  = fg_count_q;
      count_val_d = 1'b0;
      if (latch_now) begin
         cnt_d       = '0;
         fg_count_d  = cnt_inc;
         count_val_d = 1'b1;
      end
   end

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         a_d_q       <= '0;
         b_d_q       <= '0;
         sum_q       <= '0;
         vld1_q      <= 1'b0;
         grey_q      <= '0;
         bin_q       <= 1'b0;
         dval_q      <= 1'b0;
         fe_q        <= 1'b0;
         sh_lo_q     <= '0;
         sh_hi_q     <= '0;
         sh_inv_q    <= 1'b0;
         fall1_q     <= 1'b0;
         fall2_q     <= 1'b0;
         cnt_q       <= '0;
         fg_count_q  <= '0;
         count_val_q <= 1'b0;
      end else begin
         a_d_q       <= a_d_d;
         b_d_q       <= b_d_d;
         sum_q       <= sum_d;
         vld1_q      <= vld1_d;
         grey_q      <= grey_d;
         bin_q       <= bin_d;
         dval_q      <= dval_d;
         fe_q        <= fe_d;
         sh_lo_q     <= sh_lo_d;
         sh_hi_q     <= sh_hi_d;
         sh_inv_q    <= sh_inv_d;
         fall1_q     <= fall1_d;
         fall2_q     <= fall2_d;
         cnt_q       <= cnt_d;
         fg_count_q  <= fg_count_d;
         count_val_q <= count_val_d;
      end
   end

   assign oGrey      = grey_q;
   assign oBinary    = bin_q;
   assign oDVAL      = dval_q;
   assign oFG_COUNT  = fg_count_q;
   assign oCOUNT_VAL = count_val_q;

endmodule

// File: tb/tb_bayer_quad_binarizer.sv
// Scoreboard bench for bayer_quad_binarizer: a 22-bit and a 3-bit counter instance share stimulus.
module tb_bayer_quad_binarizer;

   localparam int DW = 12;
   localparam int LW = 8;
   localparam int MAXR = 6;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [DW-1:0] iDATA = '0;
   logic          iDVAL = 1'b0;
   logic [15:0]   iX_Cont = '0;
   logic [15:0]   iY_Cont = '0;
   logic          iFrame_En = 1'b0;
   logic [DW-1:0] iTH_LO = '0;
   logic [DW-1:0] iTH_HI = '0;
   logic          iINVERT = 1'b0;

   logic [DW-1:0] oGrey, oGrey3;
   logic          oBinary, oBinary3;
   logic          oDVAL, oDVAL3;
   logic [21:0]   oFG_COUNT;
   logic [2:0]    oFG_COUNT3;
   logic          oCOUNT_VAL, oCOUNT_VAL3;

   bayer_quad_binarizer #(.DATA_W(DW), .LINE_W(LW), .CNT_W(22)) dut (
      .iCLK(clk), .iRST_N(rst_n), .iDATA(iDATA), .iDVAL(iDVAL),
      .iX_Cont(iX_Cont), .iY_Cont(iY_Cont), .iFrame_En(iFrame_En),
      .iTH_LO(iTH_LO), .iTH_HI(iTH_HI), .iINVERT(iINVERT),
      .oGrey(oGrey), .oBinary(oBinary), .oDVAL(oDVAL),
      .oFG_COUNT(oFG_COUNT), .oCOUNT_VAL(oCOUNT_VAL)
   );

   bayer_quad_binarizer #(.DATA_W(DW), .LINE_W(LW), .CNT_W(3)) dut3 (
      .iCLK(clk), .iRST_N(rst_n), .iDATA(iDATA), .iDVAL(iDVAL),
      .iX_Cont(iX_Cont), .iY_Cont(iY_Cont), .iFrame_En(iFrame_En),
      .iTH_LO(iTH_LO), .iTH_HI(iTH_HI), .iINVERT(iINVERT),
      .oGrey(oGrey3), .oBinary(oBinary3), .oDVAL(oDVAL3),
      .oFG_COUNT(oFG_COUNT3), .oCOUNT_VAL(oCOUNT_VAL3)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad = 0;

   typedef struct { int cyc; int grey; int bin; } dexp_t;
   typedef struct { int cyc; int c22; int c3; } cexp_t;
   dexp_t dq[$];
   cexp_t cq[$];

   int img [MAXR][LW];

   // Output monitor: pops the scoreboards as the DUT produces samples and counts
   always @(negedge clk) begin
      dexp_t d;
      cexp_t c;
      while (dq.size() > 0 && dq[0].cyc < cyc) begin
         d = dq.pop_front();
         total++; bad++;
         $display("FAIL dval_missing: got no oDVAL, required grey %0d bin %0d at cyc %0d", d.grey, d.bin, d.cyc);
      end
      while (cq.size() > 0 && cq[0].cyc < cyc) begin
         c = cq.pop_front();
         total++; bad++;
         $display("FAIL count_missing: got no oCOUNT_VAL, required count %0d at cyc %0d", c.c22, c.cyc);
      end
      if (oDVAL || oDVAL3) begin
         total++;
         if (dq.size() == 0) begin
            bad++;
            $display("FAIL dval_spurious: got oDVAL grey %0d bin %0d at cyc %0d, required no output", oGrey, oBinary, cyc);
         end else begin
            d = dq.pop_front();
            if (oDVAL !== 1'b1 || oDVAL3 !== 1'b1 || d.cyc !== cyc
                || oGrey !== d.grey[DW-1:0] || oBinary !== d.bin[0]
                || oGrey3 !== d.grey[DW-1:0] || oBinary3 !== d.bin[0]) begin
               bad++;
               $display("FAIL quad_out: got grey %0d/%0d bin %0d/%0d at cyc %0d, required grey %0d bin %0d at cyc %0d",
                        oGrey, oGrey3, oBinary, oBinary3, cyc, d.grey, d.bin, d.cyc);
            end
         end
      end
      if (oCOUNT_VAL || oCOUNT_VAL3) begin
         total++;
         if (cq.size() == 0) begin
            bad++;
            $display("FAIL count_spurious: got oCOUNT_VAL count %0d at cyc %0d, required no pulse", oFG_COUNT, cyc);
         end else begin
            c = cq.pop_front();
            if (oCOUNT_VAL !== 1'b1 || oCOUNT_VAL3 !== 1'b1 || c.cyc !== cyc
                || oFG_COUNT !== 22'(c.c22) || oFG_COUNT3 !== 3'(c.c3)) begin
               bad++;
               $display("FAIL fg_count: got %0d/%0d at cyc %0d, required %0d/%0d at cyc %0d",
                        oFG_COUNT, oFG_COUNT3, cyc, c.c22, c.c3, c.cyc);
            end
         end
      end
   end

   task automatic fill_random();
      for (int y = 0; y < MAXR; y++)
         for (int x = 0; x < LW; x++)
            img[y][x] = int'($urandom_range(4095));
   endtask

   task automatic fill_const(input int v);
      for (int y = 0; y < MAXR; y++)
         for (int x = 0; x < LW; x++)
            img[y][x] = v;
   endtask

   // Drives one frame; model results use the thresholds in force at the frame start
   task automatic run_frame(input int nr, input int lo, input int hi, input int inv,
                            input int gap_pct, input int new_hi, input int abort_row, input int gap);
      int fg;
      int g;
      int b;
      dexp_t e;
      cexp_t c;
      fg = 0;
      @(negedge clk);
      iTH_LO = DW'(lo); iTH_HI = DW'(hi); iINVERT = inv[0];
      iFrame_En = 1'b1; iDVAL = 1'b0;
      for (int y = 0; y < nr; y++) begin
         for (int x = 0; x < LW; x++) begin
            if (int'($urandom_range(99)) < gap_pct) begin
               repeat ($urandom_range(1, 3)) begin
                  @(negedge clk);
                  iDVAL = 1'b0;
               end
            end
            @(negedge clk);
            iDVAL = 1'b1; iDATA = DW'(img[y][x]);
            iX_Cont = 16'(x); iY_Cont = 16'(y);
            if (new_hi >= 0 && y == 2 && x == 0) iTH_HI = DW'(new_hi);
            if (y == abort_row && x == 3) begin
               #2 rst_n = 1'b0;
               #1;
               total++;
               if (oGrey !== '0 || oBinary !== 1'b0 || oDVAL !== 1'b0
                   || oFG_COUNT !== '0 || oCOUNT_VAL !== 1'b0) begin
                  bad++;
                  $display("FAIL midframe_reset: got grey %0d bin %0d dval %0d count %0d cval %0d, required all 0",
                           oGrey, oBinary, oDVAL, oFG_COUNT, oCOUNT_VAL);
               end
               dq.delete();
               cq.delete();
               iDVAL = 1'b0; iFrame_En = 1'b0;
               repeat (3) @(negedge clk);
               rst_n = 1'b1;
               repeat (3) @(negedge clk);
               return;
            end
            if ((x % 2) == 1 && (y % 2) == 1) begin
               g = (img[y][x] + img[y][x-1] + img[y-1][x] + img[y-1][x-1]) / 4;
               b = ((g >= lo && g <= hi) ? 0 : 1) ^ inv;
               e.cyc = cyc + 2; e.grey = g; e.bin = b;
               dq.push_back(e);
               fg += b;
            end
         end
      end
      @(negedge clk);
      iDVAL = 1'b0; iFrame_En = 1'b0;
      c.cyc = cyc + 3; c.c22 = fg; c.c3 = (fg > 7) ? 7 : fg;
      cq.push_back(c);
      repeat (gap) @(negedge clk);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      total++;
      if (oGrey !== '0 || oBinary !== 1'b0 || oDVAL !== 1'b0 || oFG_COUNT !== '0 || oCOUNT_VAL !== 1'b0
          || oFG_COUNT3 !== '0 || oCOUNT_VAL3 !== 1'b0) begin
         bad++;
         $display("FAIL reset_state: got grey %0d bin %0d dval %0d count %0d cval %0d, required all 0",
                  oGrey, oBinary, oDVAL, oFG_COUNT, oCOUNT_VAL);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_flat_field();
      fill_const(1000);
      run_frame(4, 205, 255, 0, 0, -1, -1, 6);
   endtask

   task automatic set_arith_quads();
      fill_random();
      img[0][0] = 4095; img[0][1] = 4095; img[1][0] = 4095; img[1][1] = 4094;
      img[0][2] = 210;  img[0][3] = 211;  img[1][2] = 212;  img[1][3] = 213;
   endtask

   task automatic test_quad_arith();
      set_arith_quads();
      run_frame(4, 205, 255, 0, 0, -1, -1, 6);
   endtask

   task automatic test_invert_empty();
      set_arith_quads();
      run_frame(4, 205, 255, 1, 0, -1, -1, 6);
      fill_random();
      run_frame(4, 300, 100, 0, 0, -1, -1, 6);
   endtask

   task automatic test_shadow();
      set_arith_quads();
      img[2][2] = 210; img[2][3] = 211; img[3][2] = 212; img[3][3] = 213;
      run_frame(4, 205, 255, 0, 0, 100, -1, 6);
      run_frame(4, 205, 100, 0, 0, -1, -1, 6);
   endtask

   task automatic test_saturation();
      fill_const(1000);
      img[0][2] = 210; img[0][3] = 211; img[1][2] = 212; img[1][3] = 213;
      img[4][6] = 211; img[4][7] = 211; img[5][6] = 211; img[5][7] = 211;
      run_frame(6, 205, 255, 0, 0, -1, -1, 6);
   endtask

   task automatic test_dval_gaps();
      fill_random();
      run_frame(4, 1000, 3000, 0, 0, -1, -1, 6);
      run_frame(4, 1000, 3000, 0, 40, -1, -1, 6);
   endtask

   task automatic test_back_to_back();
      fill_random();
      run_frame(4, 0, 2047, 0, 0, -1, -1, 3);
      run_frame(4, 2048, 4095, 1, 0, -1, -1, 3);
      run_frame(4, 1500, 2500, 0, 0, -1, -1, 6);
   endtask

   task automatic test_reset_midframe();
      fill_const(1000);
      run_frame(4, 205, 255, 0, 0, -1, 3, 6);
      fill_random();
      run_frame(4, 500, 3500, 0, 0, -1, -1, 6);
   endtask

   task automatic test_drain();
      repeat (10) @(negedge clk);
      total++;
      if (dq.size() != 0 || cq.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d data and %0d count expectations pending, required 0", dq.size(), cq.size());
      end
   endtask

   initial begin
      test_reset();
      test_flat_field();
      test_quad_arith();
      test_invert_empty();
      test_shadow();
      test_saturation();
      test_dval_gaps();
      test_back_to_back();
      test_reset_midframe();
      test_drain();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
